serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial add/subtract sequencer built around a single 1-bit fulladder
//  instance (ports x,y,z,s,c). It loads two WIDTH-bit operands and feeds them
//  through the full adder LSB-first, one bit per clock, holding the carry in a flop.
//  It returns sum, carry-out and signed overflow with a start/ready/done handshake.
//  It is the area-minimal arithmetic unit for control paths that tolerate WIDTH-cycle latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 1..32
// PORTS
//  clk    in   1      system clock, rising edge
//  rst    in   1      synchronous reset, active-high
//  start  in   1      request; sampled only while ready=1
//  sub    in   1      0: a+b+cin, 1: a-b (cin ignored)
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in for add, captured on accepted start
//  ready  out  1      1 in IDLE only; block can accept start
//  busy   out  1      1 in RUN only
//  done   out  1      1-cycle pulse; result valid from this cycle
//  sum    out  WIDTH  result; held until the next accepted start
//  cout   out  1      carry-out (sub: 1 = no borrow); held like sum
//  ovf    out  1      signed overflow = carry into MSB ^ carry out of MSB; held
// BEHAVIOUR
//  Single clock domain. All state and outputs are flops. Reset is synchronous to clk.
//  Reset (rst=1 at an edge): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0,
//   bit counter=0, carry flop=0. This applies in any state; an in-flight operation is
//   discarded and no done is issued.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: if start=1 at edge E0, the block does the following:
//    - loads a_sr=a;
//    - loads b_sr = sub ? ~b : b;
//    - loads carry = sub ? 1 : cin;
//    - sets cnt=0 and goes to RUN.
//    sum/cout/ovf keep their old values until DONE.
//   RUN: each edge, fulladder(x=a_sr[0], y=b_sr[0], z=carry):
//    - s is shifted into the MSB of the sum shift register;
//    - a_sr and b_sr shift right;
//    - carry <= c;
//    - cnt increments.
//    On the edge where cnt==WIDTH-1:
//    - cout <= c and ovf <= carry ^ c (the carry flop holds the carry into the MSB);
//    - the state goes to DONE.
//   DONE: done=1 for exactly this one cycle and sum is final. The next edge goes to IDLE.
//  Latency: done is visible after WIDTH edges following E0. The next start can be
//   sampled at the edge after DONE, so the throughput is 1 op per WIDTH+2 cycles.
//  start while busy=1 or done=1 is ignored. It is not queued and has no effect on the operation.
//  a, b, sub and cin may change freely after E0; only the captured copies are used.
//  WIDTH=1: RUN lasts one edge, and ovf = carry-in ^ carry-out of that bit.
//  sum is the shift register itself. It is only visible as the final result in DONE and
//   later states. During RUN it may show partial shifts; consumers qualify it with done/ready.
//  Arithmetic is modulo 2^WIDTH. There is no saturation.
// TESTING
//  1 WIDTH=8: a=0x5A, b=0x3C, sub=0, cin=0 -> done 8 edges after start; sum=0x96, cout=0, ovf=1.
//  2 WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0;
//    same operands with cin=1 -> sum=0x01, cout=1.
//  3 WIDTH=8: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0;
//    a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
//  4 start held high and operands changed during RUN -> exactly one done, result of the
//    captured operands; a new op starts only after ready=1; the edge count matches.
//  5 rst=1 asserted at RUN bit 4 -> next cycle ready=1, busy=0, sum=0, cout=0, ovf=0,
//    and no done pulse; a following op a=3, b=4 -> sum=7.
//  6 WIDTH=1 build: all 8 (a,b,cin) combos -> sum/cout match the truth table; done 1 edge
//    after start; plus 200 random 8-bit ops checked against a behavioural model.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder, LSB-first, one bit per clock.
// Returns sum, carry-out and signed overflow behind a start/ready/done handshake.

module fulladder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] a_shr;
    logic [WIDTH-1:0] b_shr;
    logic [WIDTH-1:0] sum_shr;

    fulladder u_fa (
        .x (a_sr_q[0]),
        .y (b_sr_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    // Shift forms written without part-selects so WIDTH=1 stays legal.
    always_comb begin
        a_shr              = a_sr_q >> 1;
        b_shr              = b_sr_q >> 1;
        sum_shr            = sum_q >> 1;
        sum_shr[WIDTH-1]   = fa_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        // Subtraction is a + ~b + 1.
                        a_sr_q  <= a_i;
                        b_sr_q  <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | cin_i;
                        cnt_q   <= '0;
                        state_q <= StRun;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    sum_q   <= sum_shr;
                    a_sr_q  <= a_shr;
                    b_sr_q  <= b_shr;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        // carry_q is the carry into the MSB on this last bit.
                        cout_q  <= fa_c;
                        ovf_q   <= carry_q ^ fa_c;
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign ovf_o   = ovf_q;

endmodule
